// File: rtl/reg64_arbiter.sv
// Shared-register write arbiter: N_REQ requesters contend for one DW-bit register.
// Define REG64_ARB_FIXED_PRIO_EN for fixed priority; default build is round-robin.
module reg64_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 64,
  parameter int HOLD_CYC = 2,
  localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*DW-1:0]    req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [GW-1:0]          grant_id,
  output logic [DW-1:0]          data_out,
  output logic                   data_valid,
  output logic                   busy
);

  // state | meaning
  // IDLE  | searching for a requester
  // GRANT | req_ready asserted to grant_id, transfer on this edge if still valid
  // HOLD  | post-write quiet window of HOLD_CYC cycles
  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  localparam logic [3:0]    HOLD_LOAD = 4'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [GW-1:0] LAST_RST  = GW'(N_REQ - 1);

  state_t           state_q;
  logic [GW-1:0]    last_grant_q;
  logic [GW-1:0]    grant_q;
  logic [N_REQ-1:0] ready_q;
  logic [DW-1:0]    data_q;
  logic             dv_q;
  logic             busy_q;
  logic [3:0]       hold_q;

  logic [GW-1:0]    winner_d;
  logic             found_d;
  logic [GW-1:0]    idx;
  int               sum;

  always_comb begin
    winner_d = '0;
    found_d  = 1'b0;
    idx      = '0;
    sum      = 0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef REG64_ARB_FIXED_PRIO_EN
      sum = k;
`else
      sum = (int'(last_grant_q) + 1 + k) % N_REQ;
`endif
      idx = GW'(sum);
      if (!found_d && req_valid[idx]) begin
        found_d  = 1'b1;
        winner_d = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      grant_q      <= '0;
      ready_q      <= '0;
      data_q       <= '0;
      dv_q         <= 1'b0;
      busy_q       <= 1'b0;
      hold_q       <= '0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q <= winner_d;
            ready_q <= {{(N_REQ-1){1'b0}}, 1'b1} << winner_d;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          ready_q <= '0;
          if (req_valid[grant_q]) begin
            data_q       <= req_data[grant_q*DW +: DW];
            dv_q         <= 1'b1;
            last_grant_q <= grant_q;
            if (HOLD_CYC == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= HOLD;
              hold_q  <= HOLD_LOAD;
            end
          end else begin
            // withdrawn request: no write, priority pointer untouched
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_q == 4'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign grant_id   = grant_q;
  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reg64_arbiter.sv
// Directed bench for reg64_arbiter: HOLD_CYC=2 instance plus a HOLD_CYC=0 instance.
// Expectations follow REG64_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_reg64_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [255:0] req_data;

  logic [3:0]   ready,  ready0;
  logic [1:0]   gid,    gid0;
  logic [63:0]  dout,   dout0;
  logic         dv,     dv0;
  logic         busy,   busy0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg64_arbiter #(.N_REQ(4), .DW(64), .HOLD_CYC(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready), .grant_id(gid), .data_out(dout), .data_valid(dv), .busy(busy));

  reg64_arbiter #(.N_REQ(4), .DW(64), .HOLD_CYC(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready0), .grant_id(gid0), .data_out(dout0), .data_valid(dv0), .busy(busy0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot", 64'($countones(ready) <= 1 && $countones(ready0) <= 1), 64'd1);
  endtask

  task automatic set_data(input int i, input logic [63:0] v);
    req_data[i*64 +: 64] = v;
  endtask

  task automatic set_all_inc();
    for (int i = 0; i < 4; i++) set_data(i, 64'(i + 1));
  endtask

  task automatic wait_dv(input string tag, input bit use0);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(use0 ? dv0 : dv) && n < 20);
    chk(tag, 64'(use0 ? dv0 : dv), 64'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_d;
    int n;

    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    set_all_inc();
    step();
    step();
    chk("rst_dout",  dout,  64'd0);
    chk("rst_dv",    64'(dv),    64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_gid",   64'(gid),   64'd0);

    // single write from requester 2
    reset     = 1'b0;
    req_valid = 4'b0100;
    set_data(2, 64'h0000_0000_DEAD_BEEF);
    step();
    chk("sw_ready", 64'(ready), 64'b0100);
    chk("sw_gid",   64'(gid),   64'd2);
    chk("sw_busy1", 64'(busy),  64'd1);
    chk("sw_dv0",   64'(dv),    64'd0);
    step();
    chk("sw_dout",  dout,       64'hDEAD_BEEF);
    chk("sw_dv1",   64'(dv),    64'd1);
    chk("sw_ready0",64'(ready), 64'd0);
    req_valid = 4'b0000;
    step();
    chk("sw_dv_once", 64'(dv),  64'd0);
    chk("sw_busy_h",  64'(busy),64'd1);
    step();
    chk("sw_busy_end",64'(busy),64'd0);

    // fairness: all requesters held, data i+1
    req_valid = 4'b1111;
    set_all_inc();
    pulse_reset();
    for (int w = 0; w < 16; w++) begin
      wait_dv("fair_dv", 1'b0);
`ifdef REG64_ARB_FIXED_PRIO_EN
      exp_d = 64'd1;
`else
      exp_d = 64'((w % 4) + 1);
`endif
      chk("fair_dout", dout, exp_d);
    end

    // withdraw: previous value 9, requester 1 drops in GRANT
    req_valid = 4'b0000;
    pulse_reset();
    set_data(0, 64'd9);
    req_valid = 4'b0001;
    wait_dv("wd_dv9", 1'b0);
    chk("wd_d9", dout, 64'd9);
    req_valid = 4'b0000;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk("wd_idle", 64'(busy), 64'd0);
    set_data(1, 64'h11);
    req_valid = 4'b0010;
    step();
    chk("wd_gid1",  64'(gid),   64'd1);
    chk("wd_ready", 64'(ready), 64'b0010);
    req_valid = 4'b0000;
    step();
    chk("wd_nodv",  64'(dv),    64'd0);
    chk("wd_keep",  dout,       64'd9);
    chk("wd_busy",  64'(busy),  64'd0);
    set_all_inc();
    req_valid = 4'b1111;
    step();
`ifdef REG64_ARB_FIXED_PRIO_EN
    chk("wd_next_gid", 64'(gid), 64'd0);
    step();
    chk("wd_next_d",   dout,     64'd1);
`else
    chk("wd_next_gid", 64'(gid), 64'd1);
    step();
    chk("wd_next_d",   dout,     64'd2);
`endif
    chk("wd_next_dv",  64'(dv),  64'd1);

    // mid-operation reset in HOLD then in GRANT
    set_data(0, 64'd5);
    set_data(1, 64'd6);
    set_data(2, 64'd7);
    set_data(3, 64'd8);
    reset = 1'b1;
    step();
    chk("mr_h_dout",  dout,       64'd0);
    chk("mr_h_busy",  64'(busy),  64'd0);
    chk("mr_h_dv",    64'(dv),    64'd0);
    reset = 1'b0;
    step();
    chk("mr_gid0",    64'(gid),   64'd0);
    chk("mr_ready0",  64'(ready), 64'b0001);
    reset = 1'b1;
    step();
    chk("mr_g_dout",  dout,       64'd0);
    chk("mr_g_dv",    64'(dv),    64'd0);
    chk("mr_g_busy",  64'(busy),  64'd0);
    chk("mr_g_ready", 64'(ready), 64'd0);
    reset = 1'b0;
    step();
    chk("mr_rel_gid", 64'(gid),   64'd0);
    step();
    chk("mr_rel_d",   dout,       64'd5);
    chk("mr_rel_dv",  64'(dv),    64'd1);

    // HOLD_CYC=0 instance: one write every 2 cycles
    set_all_inc();
    req_valid = 4'b1111;
    pulse_reset();
    wait_dv("h0_first", 1'b1);
    chk("h0_d1", dout0, 64'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("h0_dv", 64'(dv0), 64'((k % 2) == 0));
      if ((k % 2) == 0) begin
`ifdef REG64_ARB_FIXED_PRIO_EN
        exp_d = 64'd1;
`else
        exp_d = 64'(((k / 2) % 4) + 1);
`endif
        chk("h0_dout", dout0, exp_d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg64_arbiter.md
REG64_ARBITER -- requirements
Module: reg64_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, sets the number of requesters (2..8).
REQ-002 Parameter DW, default 64, sets the shared register width.
REQ-003 Parameter HOLD_CYC, default 2, sets the post-write hold window in cycles (0..15).
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester write request.
REQ-007 req_data  in  N_REQ*DW  write data; requester i occupies bits [i*DW +: DW].
REQ-008 req_ready  out  N_REQ  one-hot grant strobe; transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-009 grant_id  out  clog2(N_REQ)  index of the current or last granted requester.
REQ-010 data_out  out  DW  shared 64-bit register contents.
REQ-011 data_valid  out  1  one-cycle pulse marking that data_out was just updated.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT and HOLD.
REQ-014 In IDLE with any req_valid set, the block SHALL latch the winner into grant_id and move to GRANT on the next edge; with no req_valid set it SHALL stay in IDLE.
REQ-015 Round-robin: the search SHALL start at (last_grant+1) mod N_REQ and pick the first requester with req_valid set.
REQ-016 In GRANT, req_ready SHALL be one-hot at bit grant_id; in every other state req_ready SHALL be all zeros.
REQ-017 In GRANT with req_valid[grant_id]=1, at the edge:
- data_out <= req_data slice of grant_id
- data_valid <= 1 for exactly one cycle
- last_grant <= grant_id
- the FSM moves to HOLD, or to IDLE if HOLD_CYC=0
REQ-018 In GRANT with req_valid[grant_id]=0 (request withdrawn), the block SHALL:
- leave data_out unchanged
- not pulse data_valid
- leave last_grant unchanged
- return to IDLE
REQ-019 HOLD SHALL last exactly HOLD_CYC cycles, issue no grants, and then go to IDLE.
REQ-020 Latency from req_valid sampled in IDLE to updated data_out SHALL be 2 cycles; minimum spacing between writes SHALL be 2+HOLD_CYC cycles.
REQ-021 Requests arriving in GRANT or HOLD SHALL be held off; requesters keep req_valid and req_data stable until they see ready.
REQ-022 When all N_REQ requesters are asserted continuously, grants SHALL rotate 0,1,...,N_REQ-1,0 with no starvation.
REQ-023 The arbiter SHALL never drive more than one req_ready bit high in the same cycle.

Reset
REQ-024 While reset=1 at an edge:
- FSM <= IDLE, data_out <= 0, data_valid <= 0, grant_id <= 0, busy <= 0, req_ready <= 0
- last_grant <= N_REQ-1, so requester 0 has first priority
- the hold counter <= 0
REQ-025 A reset asserted in GRANT or HOLD SHALL discard the pending transfer, with no data_out update and no data_valid pulse.

Configuration
REQ-026 The macro REG64_ARB_FIXED_PRIO_EN selects the arbitration policy:
- defined: fixed priority, lowest asserted index always wins, last_grant ignored
- undefined: round-robin per REQ-015
- all other behaviour is identical in both builds

Verification
REQ-027 Reset: assert reset for 2 cycles with all req_valid=1 -> data_out=0, data_valid=0, busy=0, req_ready=0.
REQ-028 Single write: only req_valid[2]=1 with data 64'h0000_0000_DEAD_BEEF -> req_ready[2] high for 1 cycle, data_out=64'hDEADBEEF 2 cycles after the request, data_valid pulses once, busy low again after 2+HOLD_CYC cycles.
REQ-029 Fairness: all four requests held with data i+1 for 16 writes -> data_out sequence 1,2,3,4,1,2,3,4,... (round-robin); with REG64_ARB_FIXED_PRIO_EN defined -> always 1.
REQ-030 Withdraw: req_valid[1] dropped during GRANT -> no data_valid, data_out retains the previous value 64'd9, and the next IDLE search still starts at index last_grant+1.
REQ-031 Mid-operation reset: reset asserted during HOLD and GRANT with data 64'd5 -> data_out=0, FSM in IDLE, requester 0 granted first after release.
REQ-032 HOLD_CYC=0 build with continuous requests -> one write every 2 cycles and data_valid toggling 1,0,1,0.
